uart_rx_param: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 8-bit receiver. Oversamples rx_in, majority-votes each
//  bit, supports 5..9 data bits, optional parity, 1 or 2 stop bits. Delivers words over a valid/ready

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_tick_gen.sv | 29 ++
 rtl/uart_rx_param.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Holds the rx state encoding, parity mode codes and the tick divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE2 = 2'b11
  } par_mode_e;

  // Clocks per oversample tick; never below one.
  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    int d;
    d = clk_hz / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Word delivery handshake of the UART receiver.
// data_out/data_valid from receiver, data_ready from consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one-clk pulse every DIV clocks.
// Ports: clk, reset (async active-low), i_restart (sync clear), o_tick.
module uart_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_restart || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = !i_restart && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample vote, 5..9 data bits, 1/2 stop bits.
// Ports: clk, reset (async low), rx_in, rx_if (data_out/valid/ready),
//   busy, frame_err, overrun_err, parity_err; parity_mode with UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0] parity_mode,
`endif
  uart_rx_param_if.master rx_if,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_V0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_V1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_V2  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_ALL = BW'(DATA_BITS);
  localparam logic          S_LST = 1'(STOP_BITS - 1);

  logic r_sync1, r_sync2, r_sync3;
  rx_state_e r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic [1:0] r_smp;
  logic [BW-1:0] r_bcnt;
  logic r_scnt;
  logic [DATA_BITS-1:0] r_shift;
  logic r_par, r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic r_valid, r_ferr, r_oerr, r_perr_p;

  logic w_fall, w_restart, w_tick;
  logic w_vote_tick, w_end_tick, w_vote;
  logic w_shift_en, w_par_chk, w_ferr, w_done;
  logic w_par_on, w_par_odd;

`ifdef UART_RX_PARITY_EN
  assign w_par_on  = (parity_mode == PAR_EVEN) ||
                     (parity_mode == PAR_ODD);
  assign w_par_odd = (parity_mode == PAR_ODD);
`else
  assign w_par_on  = 1'b0;
  assign w_par_odd = 1'b0;
`endif

  assign w_fall    = r_sync3 & ~r_sync2;
  assign w_restart = (r_state == ST_IDLE) && w_fall;

  uart_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  assign w_vote_tick = w_tick && (r_tcnt == T_V2);
  assign w_end_tick  = w_tick && (r_tcnt == T_END);
  // Third sample is the live synchronized line at the vote tick.
  assign w_vote = (r_smp[1] & r_smp[0]) |
                  (r_smp[1] & r_sync2) |
                  (r_smp[0] & r_sync2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_par_chk  = 1'b0;
    w_ferr     = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fall) w_next = ST_START;
      end
      ST_START: begin
        if (w_vote_tick && w_vote) w_next = ST_IDLE;
        else if (w_end_tick)       w_next = ST_DATA;
      end
      ST_DATA: begin
        w_shift_en = w_vote_tick;
        if (w_end_tick && r_bcnt == B_ALL)
          w_next = w_par_on ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        w_par_chk = w_vote_tick;
        if (w_end_tick) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_vote_tick) begin
          if (!w_vote) begin
            w_ferr = 1'b1;
            w_next = ST_WAIT_HIGH;
          end else if (r_scnt == S_LST) begin
            // Do not wait out the tail of the stop bit.
            w_done = 1'b1;
            w_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (r_sync2) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt  <= '0;
      r_smp   <= '0;
      r_bcnt  <= '0;
      r_scnt  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
    end else if (w_restart) begin
      r_tcnt <= '0;
      r_bcnt <= '0;
      r_scnt <= 1'b0;
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_tick) begin
        r_tcnt <= (r_tcnt == T_END) ? '0 : r_tcnt + 1'b1;
        if (r_tcnt == T_V0) r_smp[1] <= r_sync2;
        if (r_tcnt == T_V1) r_smp[0] <= r_sync2;
      end
      if (w_shift_en) begin
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
        r_par   <= r_par ^ w_vote;
        r_bcnt  <= r_bcnt + 1'b1;
      end
      if (w_par_chk)
        r_perr <= (w_vote != (r_par ^ w_par_odd));
      if (r_state == ST_STOP && w_end_tick)
        r_scnt <= r_scnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_oerr   <= 1'b0;
      r_perr_p <= 1'b0;
    end else begin
      r_ferr   <= w_ferr;
      r_oerr   <= 1'b0;
      r_perr_p <= 1'b0;
      if (w_done) begin
        if (r_valid && !rx_if.data_ready) begin
          r_oerr <= 1'b1;
        end else begin
          r_data   <= r_shift;
          r_valid  <= 1'b1;
          r_perr_p <= r_perr;
        end
      end else if (r_valid && rx_if.data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.data_out   = r_data;
  assign rx_if.data_valid = r_valid;
  assign busy        = (r_state == ST_START) || (r_state == ST_DATA) ||
                       (r_state == ST_PARITY) || (r_state == ST_STOP);
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;
  assign parity_err  = r_perr_p;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 and 9-bit/2-stop instances driven by
// a serial line model; outputs compared to an expected word queue.
module tb_uart_rx_param;

  localparam int CLK_HZ   = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx8 = 1'b1;
  logic rx9 = 1'b1;
  logic busy8, ferr8, oerr8, perr8;
  logic busy9, ferr9, oerr9, perr9;

  int n_vec = 0;
  int n_miss = 0;

  uart_rx_param_if #(.DATA_BITS(8)) if8 ();
  uart_rx_param_if #(.DATA_BITS(9)) if9 ();

`ifdef UART_RX_PARITY_EN
  logic [1:0] pm8 = 2'b00;
  logic [1:0] pm9 = 2'b00;
`endif

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .STOP_BITS(1)
  ) u_rx8 (
    .clk(clk), .reset(reset), .rx_in(rx8),
`ifdef UART_RX_PARITY_EN
    .parity_mode(pm8),
`endif
    .rx_if(if8.master), .busy(busy8),
    .frame_err(ferr8), .overrun_err(oerr8), .parity_err(perr8)
  );

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(9), .STOP_BITS(2)
  ) u_rx9 (
    .clk(clk), .reset(reset), .rx_in(rx9),
`ifdef UART_RX_PARITY_EN
    .parity_mode(pm9),
`endif
    .rx_if(if9.master), .busy(busy9),
    .frame_err(ferr9), .overrun_err(oerr9), .parity_err(perr9)
  );

  always #5 clk = ~clk;

  // Output monitor: accepted words and pulse counts.
  logic [8:0] got8[$];
  logic [8:0] got9[$];
  int nf8 = 0, no8 = 0, np8 = 0, nvh8 = 0;
  int nf9 = 0, no9 = 0, np9 = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (ferr8) nf8++;
      if (oerr8) no8++;
      if (perr8) np8++;
      if (if8.data_valid) nvh8++;
      if (if8.data_valid && if8.data_ready)
        got8.push_back({1'b0, if8.data_out});
      if (ferr9) nf9++;
      if (oerr9) no9++;
      if (perr9) np9++;
      if (if9.data_valid && if9.data_ready)
        got9.push_back(if9.data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic line_bit(input bit sel9, input logic v);
    if (sel9) rx9 = v;
    else      rx8 = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send(input bit sel9, input logic [8:0] d, input int nb,
                      input bit pen, input logic pb, input int ns,
                      input bit bad_last);
    line_bit(sel9, 1'b0);
    for (int i = 0; i < nb; i++) line_bit(sel9, d[i]);
    if (pen) line_bit(sel9, pb);
    for (int i = 0; i < ns; i++)
      line_bit(sel9, (bad_last && i == ns - 1) ? 1'b0 : 1'b1);
    if (sel9) rx9 = 1'b1;
    else      rx8 = 1'b1;
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic chk_words(input string tag, input bit sel9,
                           input int base, input logic [8:0] exp[$]);
    int n;
    n = sel9 ? got9.size() - base : got8.size() - base;
    chk({tag, "_count"}, n, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < n)
        chk(tag, sel9 ? got9[base+i] : got8[base+i], exp[i]);
    end
  endtask

  logic [8:0] exq[$];
  int b8, b9, f8, o8, p8, v8, f9, o9, p9, ef;
  logic [8:0] d;
  bit bad;

  task automatic snap();
    b8 = got8.size(); b9 = got9.size();
    f8 = nf8; o8 = no8; p8 = np8; v8 = nvh8;
    f9 = nf9; o9 = no9; p9 = np9;
    exq = {};
  endtask

  initial begin
    if8.data_ready = 1'b1;
    if9.data_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data", if8.data_out, 0);
    chk("rst_valid", if8.data_valid, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_errs", {ferr8, oerr8, perr8}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", {if8.data_valid, if9.data_valid}, 0);
    chk("post_rst_busy", {busy8, busy9}, 0);

    // single 0xA5 with the consumer always ready
    snap();
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 0);
    chk("a5_busy_end", busy8, 0);
    idle(1);
    exq.push_back(9'h0A5);
    chk_words("a5_word", 0, b8, exq);
    chk("a5_valid_clks", nvh8 - v8, 1);
    chk("a5_errs", (nf8 - f8) + (no8 - o8) + (np8 - p8), 0);

    // random 8N1 traffic with occasional broken stop bit
    snap();
    ef = 0;
    for (int k = 0; k < 12; k++) begin
      d = 9'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send(0, d, 8, 0, 1'b0, 1, bad);
      if (bad) begin
        ef++;
        idle(1);
      end else begin
        exq.push_back(d);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
    end
    idle(1);
    chk_words("rand8_word", 0, b8, exq);
    chk("rand8_ferr", nf8 - f8, ef);
    chk("rand8_oerr", no8 - o8, 0);

    // overrun: two words while consumer stalls
    snap();
    if8.data_ready = 1'b0;
    send(0, 9'h055, 8, 0, 1'b0, 1, 0);
    send(0, 9'h033, 8, 0, 1'b0, 1, 0);
    idle(1);
    chk("ovr_hold_data", if8.data_out, 8'h55);
    chk("ovr_hold_valid", if8.data_valid, 1);
    chk("ovr_pulses", no8 - o8, 1);
    if8.data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exq.push_back(9'h055);
    chk_words("ovr_word", 0, b8, exq);
    chk("ovr_valid_drop", if8.data_valid, 0);

    // false start: 0.3 bit of low
    snap();
    rx8 = 1'b0;
    repeat (BIT_CLKS * 3 / 10) @(negedge clk);
    chk("fs_busy_rise", busy8, 1);
    rx8 = 1'b1;
    idle(1);
    chk("fs_busy_drop", busy8, 0);
    chk("fs_no_out", (nvh8 - v8) + (nf8 - f8), 0);

    // reset mid-frame drops held word and partial 0xFF
    if8.data_ready = 1'b0;
    send(0, 9'h05A, 8, 0, 1'b0, 1, 0);
    idle(1);
    chk("mid_held", if8.data_valid, 1);
    line_bit(0, 1'b0);
    line_bit(0, 1'b1);
    line_bit(0, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_clear", {if8.data_valid, busy8}, 0);
    chk("mid_rst_data", if8.data_out, 0);
    reset = 1'b1;
    if8.data_ready = 1'b1;
    snap();
    idle(7);
    send(0, 9'h012, 8, 0, 1'b0, 1, 0);
    idle(1);
    exq.push_back(9'h012);
    chk_words("mid_word", 0, b8, exq);
    chk("mid_ferr", nf8 - f8, 0);

    // line stuck low for three frames: single framing error
    snap();
    rx8 = 1'b0;
    idle(30);
    rx8 = 1'b1;
    idle(1);
    chk("brk_ferr", nf8 - f8, 1);
    chk("brk_words", got8.size() - b8, 0);
    send(0, 9'h03C, 8, 0, 1'b0, 1, 0);
    idle(1);
    exq.push_back(9'h03C);
    chk_words("brk_recover", 0, b8, exq);

    // 9 data bits, 2 stop bits
    snap();
    send(1, 9'h1C3, 9, 0, 1'b0, 2, 0);
    idle(1);
    exq.push_back(9'h1C3);
    chk_words("w9_word", 1, b9, exq);
    snap();
    send(1, 9'h0A5, 9, 0, 1'b0, 2, 1);
    idle(1);
    chk("w9_ferr", nf9 - f9, 1);
    chk("w9_nowords", got9.size() - b9, 0);
    snap();
    for (int k = 0; k < 4; k++) begin
      d = 9'($urandom_range(0, 511));
      send(1, d, 9, 0, 1'b0, 2, 0);
      exq.push_back(d);
    end
    idle(1);
    chk_words("rand9_word", 1, b9, exq);
    chk("rand9_errs", (nf9 - f9) + (no9 - o9) + (np9 - p9), 0);

`ifdef UART_RX_PARITY_EN
    snap();
    pm8 = 2'b01;
    send(0, 9'h007, 8, 1, 1'b0, 1, 0);
    idle(1);
    chk("par_bad", np8 - p8, 1);
    send(0, 9'h007, 8, 1, 1'b1, 1, 0);
    idle(1);
    chk("par_good", np8 - p8, 1);
    exq.push_back(9'h007);
    exq.push_back(9'h007);
    chk_words("par_word", 0, b8, exq);
    snap();
    ef = 0;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] m;
      logic pb;
      bit pen;
      m = 2'($urandom_range(0, 3));
      pm8 = m;
      pb = 1'($urandom_range(0, 1));
      d = 9'($urandom_range(0, 255));
      pen = (m == 2'b01) || (m == 2'b10);
      // even: total count of ones incl. parity bit is even
      if (pen && (pb != ((^d[7:0]) ^ (m == 2'b10)))) ef++;
      send(0, d, 8, pen, pb, 1, 0);
      exq.push_back(d);
      idle(1);
    end
    chk_words("par_rand_word", 0, b8, exq);
    chk("par_rand_err", np8 - p8, ef);
    pm8 = 2'b00;
`else
    chk("par_tied0", np8 + np9, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
